// File: rtl/fetch_pc_unit.sv
// fetch_pc_unit: owns the architectural fetch PC, applies PCSrc redirects from EX and
// runs a single-outstanding request/response fetch to IMEM, presenting {inst, PC} to decode.
// Optional feature macro: FETCH_MISALIGN_CHECK_EN
//   defined   : misaligned redirect targets are not fetched; PC goes to the trap vector
//               and o_misaligned pulses together with o_flush.
//   undefined : o_misaligned is tied low and target bits [1:0] are forced to 00.
module fetch_pc_unit #(
   parameter int unsigned     XLEN     = 32,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input  logic            i_clk,
   input  logic            i_rst,
   input  logic            i_redirectValid,
   input  logic [1:0]      i_PCSrc,
   input  logic [XLEN-1:0] i_branchTarget,
   input  logic [XLEN-1:0] i_jalrTarget,
   input  logic [XLEN-1:0] i_mtvec,
   input  logic            i_stall,
   output logic            o_imemReq,
   output logic [XLEN-1:0] o_imemAddr,
   input  logic            i_imemGnt,
   input  logic            i_imemRvalid,
   input  logic [31:0]     i_imemRdata,
   output logic            o_instValid,
   output logic [31:0]     o_inst,
   output logic [XLEN-1:0] o_instPC,
   output logic            o_flush,
   output logic            o_misaligned
);

   localparam logic [1:0]      SRC_SEQ    = 2'b00;
   localparam logic [1:0]      SRC_BRANCH = 2'b01;
   localparam logic [1:0]      SRC_JALR   = 2'b11;
   localparam logic [XLEN-1:0] PC_STEP    = XLEN'(4);

   typedef enum logic [1:0] {
      ST_BOOT    = 2'd0,
      ST_REQ     = 2'd1,
      ST_WAIT    = 2'd2,
      ST_DISCARD = 2'd3
   } state_t;

   state_t          r_state;
   logic [XLEN-1:0] r_pc;
   logic            r_instValid;
   logic [31:0]     r_inst;
   logic [XLEN-1:0] r_instPC;
   logic            r_flush;

   logic            w_redirect;
   logic [XLEN-1:0] w_trapVec;
   logic [XLEN-1:0] w_target;
   logic            w_imemReq;
   logic            w_reqAccepted;

   assign w_redirect    = i_redirectValid & (i_PCSrc != SRC_SEQ);
   assign w_trapVec     = {i_mtvec[XLEN-1:2], 2'b00};
   // A held instruction blocks new requests so no response can overwrite it
   assign w_imemReq     = (r_state == ST_REQ) & ~(r_instValid & i_stall);
   assign w_reqAccepted = w_imemReq & i_imemGnt;

`ifdef FETCH_MISALIGN_CHECK_EN
   logic [XLEN-1:0] w_rawTarget;
   logic            w_targetMisaligned;
   logic            r_misaligned;
   logic            w_unused;

   // Resolve the raw redirect target and flag targets that are not word aligned
   always_comb begin
      w_rawTarget        = w_trapVec;
      w_targetMisaligned = 1'b0;
      case (i_PCSrc)
         SRC_BRANCH: begin
            w_rawTarget        = i_branchTarget;
            w_targetMisaligned = |i_branchTarget[1:0];
         end
         SRC_JALR: begin
            w_rawTarget        = {i_jalrTarget[XLEN-1:1], 1'b0};
            w_targetMisaligned = i_jalrTarget[1];
         end
         default: begin
            w_rawTarget        = w_trapVec;
            w_targetMisaligned = 1'b0;
         end
      endcase
   end

   assign w_target = w_targetMisaligned ? w_trapVec : w_rawTarget;

   // Misaligned-target pulse, aligned with the flush it accompanies
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_misaligned <= 1'b0;
      end else begin
         r_misaligned <= w_redirect & w_targetMisaligned;
      end
   end

   assign o_misaligned = r_misaligned;
   assign w_unused     = &{1'b0, i_mtvec[1:0], i_jalrTarget[0]};
`else
   logic w_unused;

   // Resolve the redirect target, always forced to a word boundary
   always_comb begin
      w_target = w_trapVec;
      case (i_PCSrc)
         SRC_BRANCH: w_target = {i_branchTarget[XLEN-1:2], 2'b00};
         SRC_JALR:   w_target = {i_jalrTarget[XLEN-1:2], 2'b00};
         default:    w_target = w_trapVec;
      endcase
   end

   assign o_misaligned = 1'b0;
   assign w_unused     = &{1'b0, i_mtvec[1:0], i_branchTarget[1:0], i_jalrTarget[1:0]};
`endif

   // Fetch FSM, PC register and decode output register
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state     <= ST_BOOT;
         r_pc        <= RESET_PC;
         r_instValid <= 1'b0;
         r_inst      <= '0;
         r_instPC    <= '0;
         r_flush     <= 1'b0;
      end else begin
         r_flush <= w_redirect;

         // Decode consumed the held instruction
         if (r_instValid && !i_stall) begin
            r_instValid <= 1'b0;
         end

         // Redirect wins over stall and sequential advance in every state
         if (w_redirect) begin
            r_pc        <= w_target;
            r_instValid <= 1'b0;
         end

         case (r_state)
            ST_BOOT: begin
               r_state <= ST_REQ;
            end
            ST_REQ: begin
               if (w_reqAccepted) begin
                  r_state <= w_redirect ? ST_DISCARD : ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (i_imemRvalid) begin
                  r_state <= ST_REQ;
                  if (!w_redirect) begin
                     r_inst      <= i_imemRdata;
                     r_instPC    <= r_pc;
                     r_instValid <= 1'b1;
                     r_pc        <= r_pc + PC_STEP;
                  end
               end else if (w_redirect) begin
                  r_state <= ST_DISCARD;
               end
            end
            ST_DISCARD: begin
               if (i_imemRvalid) begin
                  r_state <= ST_REQ;
               end
            end
            default: begin
               r_state <= ST_BOOT;
            end
         endcase
      end
   end

   assign o_imemReq   = w_imemReq;
   assign o_imemAddr  = r_pc;
   assign o_instValid = r_instValid;
   assign o_inst      = r_inst;
   assign o_instPC    = r_instPC;
   assign o_flush     = r_flush;

endmodule
